tis_infeed: RTL and testbench
=============================

# tis_infeed

Host-to-grid input stage for the 3x4 TIS core grid. Accepts a stream of lane-tagged 16-bit signed values from the host, buffers them per column in four show-ahead FIFOs, and presents them on the grid's top-edge ports (`up`, `rreadyU`). It consumes the grid's `readU` strobes. It is the block directly upstream of the core grid's top row.

## Interface
Parameters:
- `DEPTH`, 8: entries per lane FIFO; power of two, at least 2.
- `LANES`, 4: number of columns; fixed to the grid width.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous clear of all lanes; takes priority over push and pop.
- `in_valid` in 1: host word valid.
- `in_ready` out 1: word accepted this cycle when `in_valid && in_ready`.
- `in_lane` in 2: destination column.
- `in_data` in 16: signed host value.
- `up[0:3]` out 11 each: head value per lane, 11-bit two's complement.
- `rreadyU` out 4: lane holds a value (FIFO not empty).
- `readU` in 4: grid consumes the head of lane i.
- `level[0:3]` out $clog2(DEPTH)+1 each: occupancy per lane.

## Operation
- Push: on `in_valid && in_ready`, the converted value is written to FIFO `in_lane`.
- `in_ready` is the inverse of `full[in_lane]`, combinational from `in_lane`. It does not depend on same-cycle pops; there is no bypass.
- Pop: lane i pops when `readU[i] && rreadyU[i]`. A `readU[i]` while `rreadyU[i]` is low is ignored.
- Same-lane push and pop in the same cycle: both happen and `level` is unchanged. This is legal at full (the push is blocked by `in_ready`, so only the pop occurs). At empty, only the push occurs.
- Show-ahead: `up[i]` always holds the current head. When the lane is empty, `up[i]` holds its last value and carries no meaning.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `level` saturates at DEPTH and never reaches DEPTH+1.
- `flush`: all pointers and levels go to 0 on the next edge. A push or pop presented in the same cycle is dropped.
- Value conversion is described under Configuration.

## Timing
- Reset (async assert, synchronous release is the integrator's concern):
  - `rreadyU` = 0, `level` = 0, pointers = 0, `up` = 0.
  - `in_ready` = 1 for every lane.
- Push-to-visible latency: a word accepted at edge n gives `rreadyU[i]` = 1 and `up[i]` = value after edge n.
- Pop latency: for a pop at edge n, the next head (or `rreadyU` = 0) is visible after edge n.
- Back-to-back pops every cycle are supported. With DEPTH=2, a lane sustains one word per cycle.
- If `rst` is asserted mid-transfer, buffered data is lost; no partial state survives.

## Configuration
- With `TIS_INFEED_CLAMP_EN` defined: `in_data` saturates to [-999, 999] before truncation to 11 bits.
  - 1500 becomes 999.
  - -32768 becomes -999.
- Without the macro: the low 11 bits of `in_data` are taken unchanged.
  - 1500 becomes -548 (0x5DC to 0x5DC, 11-bit).
  - The host is then responsible for range.
- In both cases, -999..999 passes through exactly.

## Structure
- Shared package `tis_pkg` holds:
  - `VAL_W` = 11
  - `VAL_MAX` = 999
  - `VAL_MIN` = -999
  - `GRID_COLS` = 4
  - typedef `tis_val_t` = logic signed [10:0]
- Sub-module `tis_infeed_fifo`: one lane, show-ahead, with ports `clk`, `rst`, `flush`, `push`, `wdata`, `pop`, `rdata`, `empty`, `full`, `level`. It is instantiated LANES times.
- Conversion and lane decode live in the top.

## Test plan
- Reset, then push 5, -7, 999 to lane 2 on consecutive cycles. Expected:
  - `rreadyU` = 0100.
  - `up[2]` = 5.
  - With `readU[2]` pulsed each cycle, `up[2]` steps to -7, then 999, then `rreadyU[2]` = 0.
- Fill lane 0 with 8 words (DEPTH=8). Expected:
  - `in_ready` = 0 while `in_lane` = 0, and 1 with `in_lane` = 1.
  - A 9th push is held until one `readU[0]` pop, then accepted; `level[0]` stays 8.
- Same-cycle push and pop on lane 1 at `level` = 3. Expected: `level[1]` stays 3, FIFO order is preserved, and the head advances.
- Pulse `readU` = 1111 while all lanes are empty. Expected: no state change, `level` all 0, no underflow.
- Push 1500 and -2000. Expected:
  - Clamp enabled: `up` = 999 and -999.
  - Clamp disabled: `up` = 11-bit truncations -548 and 48.
- Push 3 words to lane 3, then assert `flush` together with a push and a `readU[3]`. Expected: `level[3]` = 0, `rreadyU` = 0, and the push is dropped. A mid-stream `rst` pulse gives the same result.

Source files
------------

// File: rtl/tis_pkg.sv
// Shared TIS constants and the 11-bit grid value type used by the infeed and the core grid.
package tis_pkg;
  localparam int VAL_W     = 11;
  localparam int VAL_MAX   = 999;
  localparam int VAL_MIN   = -999;
  localparam int GRID_COLS = 4;

  typedef logic signed [VAL_W-1:0] tis_val_t;
endpackage

// File: rtl/tis_infeed_if.sv
// Host-side push port and grid top-edge port of the TIS infeed, bundled as one interface.
interface tis_infeed_if #(
  parameter int DEPTH = 8
);
  import tis_pkg::*;

  localparam int LVL_W = $clog2(DEPTH) + 1;

  // Host push: a word transfers on an edge where in_valid && in_ready; in_ready never looks at in_valid.
  // Grid pop: lane i's head leaves on an edge where readU[i] && rreadyU[i]; readU[i] alone is ignored.
  logic                             in_valid;
  logic                             in_ready;
  logic [1:0]                       in_lane;
  logic [15:0]                      in_data;
  tis_val_t [GRID_COLS-1:0]         up;
  logic [GRID_COLS-1:0]             rreadyU;
  logic [GRID_COLS-1:0]             readU;
  logic [GRID_COLS-1:0][LVL_W-1:0]  level;

  modport master (
    output in_valid, in_lane, in_data, readU,
    input  in_ready, up, rreadyU, level
  );

  modport slave (
    input  in_valid, in_lane, in_data, readU,
    output in_ready, up, rreadyU, level
  );
endinterface

// File: rtl/tis_infeed_fifo.sv
// One show-ahead lane FIFO: the head is held in a register so it is valid right after the push edge.
module tis_infeed_fifo
  import tis_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  tis_val_t         wdata,
  input  logic             pop,
  output tis_val_t         rdata,
  output logic             empty,
  output logic             full,
  output logic [LVL_W-1:0] level
);
  tis_val_t         mem_q [DEPTH];
  tis_val_t         mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  tis_val_t         head_q, head_d;
  logic             do_push, do_pop;

  always_comb begin
    empty    = (level_q == '0);
    full     = (level_q == LVL_W'(DEPTH));
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    head_d   = head_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      // After a pop the new head is the next stored entry, or the word arriving on this same edge.
      if (do_pop) begin
        if (level_q > LVL_W'(1)) head_d = mem_q[rd_ptr_d];
        else if (do_push)        head_d = wdata;
      end else if (do_push && empty) begin
        head_d = wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
    end
  end

  assign rdata = head_q;
  assign level = level_q;
endmodule

// File: rtl/tis_infeed.sv
// Host-to-grid infeed: converts host words to 11-bit values and steers them into per-column FIFOs.
// Optional build macro TIS_INFEED_CLAMP_EN saturates host values to [-999, 999] before truncation.
module tis_infeed
  import tis_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LANES = GRID_COLS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  tis_infeed_if.slave  bus
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  tis_val_t         wval;
  logic [LANES-1:0] full;
  logic [LANES-1:0] empty;
  logic [LANES-1:0] push;
  logic             in_ready_w;
  tis_val_t         up_w    [LANES];
  logic [LVL_W-1:0] level_w [LANES];

`ifdef TIS_INFEED_CLAMP_EN
  localparam logic signed [15:0] CLAMP_HI = 16'(VAL_MAX);
  localparam logic signed [15:0] CLAMP_LO = 16'(VAL_MIN);

  always_comb begin
    wval = bus.in_data[VAL_W-1:0];
    if ($signed(bus.in_data) > CLAMP_HI)      wval = CLAMP_HI[VAL_W-1:0];
    else if ($signed(bus.in_data) < CLAMP_LO) wval = CLAMP_LO[VAL_W-1:0];
  end
`else
  // Out-of-range host values wrap; the host owns range checking in this build.
  logic unused_in_hi;
  assign unused_in_hi = ^bus.in_data[15:VAL_W];
  assign wval         = bus.in_data[VAL_W-1:0];
`endif

  always_comb begin
    in_ready_w = ~full[bus.in_lane];
    push       = '0;
    if (bus.in_valid && in_ready_w) push[bus.in_lane] = 1'b1;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    tis_infeed_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push[i]),
      .wdata (wval),
      .pop   (bus.readU[i]),
      .rdata (up_w[i]),
      .empty (empty[i]),
      .full  (full[i]),
      .level (level_w[i])
    );
  end

  always_comb begin
    bus.in_ready = in_ready_w;
    bus.rreadyU  = ~empty;
    for (int i = 0; i < LANES; i++) begin
      bus.up[i]    = up_w[i];
      bus.level[i] = level_w[i];
    end
  end
endmodule

// File: tb/tb_tis_infeed.sv
// Randomised and directed bench for tis_infeed; per-lane expected queues hold what each head must show.
module tb_tis_infeed;
  import tis_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;

  tis_infeed_if #(.DEPTH(DEPTH)) bus ();

  tis_infeed #(.DEPTH(DEPTH), .LANES(GRID_COLS)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [VAL_W-1:0] exp_q [GRID_COLS][$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Host value as the grid must see it: optional saturation, then 11-bit two's complement wrap.
  function automatic int ref_conv(input int v);
    int t = v;
`ifdef TIS_INFEED_CLAMP_EN
    if (t > VAL_MAX)      t = VAL_MAX;
    else if (t < VAL_MIN) t = VAL_MIN;
`endif
    t = t & 32'h7FF;
    if (t >= 1024) t = t - 2048;
    return t;
  endfunction

  always @(negedge rst) begin
    for (int i = 0; i < GRID_COLS; i++) exp_q[i].delete();
  end

  // Scoreboard: compare outputs against the model, then apply the transfers the coming edge will make.
  always @(negedge clk) begin
    if (rst) begin
      bit accept;
      for (int i = 0; i < GRID_COLS; i++) begin
        check("level", int'(bus.level[i]), exp_q[i].size());
        check("rreadyU", int'(bus.rreadyU[i]), int'(exp_q[i].size() != 0));
        if (exp_q[i].size() != 0)
          check("up_head", int'($signed(bus.up[i])), int'($signed(exp_q[i][0])));
      end
      accept = exp_q[bus.in_lane].size() < DEPTH;
      check("in_ready", int'(bus.in_ready), int'(accept));
      if (flush) begin
        for (int i = 0; i < GRID_COLS; i++) exp_q[i].delete();
      end else begin
        for (int i = 0; i < GRID_COLS; i++)
          if (bus.readU[i] && exp_q[i].size() != 0) void'(exp_q[i].pop_front());
        if (bus.in_valid && accept)
          exp_q[bus.in_lane].push_back(11'(ref_conv(int'($signed(bus.in_data)))));
      end
    end
  end

  task automatic drive(input logic v, input logic [1:0] ln, input int d,
                       input logic [3:0] rd, input logic fl);
    bus.in_valid = v;
    bus.in_lane  = ln;
    bus.in_data  = 16'(d);
    bus.readU    = rd;
    flush        = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n, input logic [3:0] rd);
    for (int k = 0; k < n; k++) drive(1'b0, 2'd0, 0, rd, 1'b0);
  endtask

  initial begin
    int exp_a, exp_b;
    bus.in_valid = 1'b0;
    bus.in_lane  = 2'd0;
    bus.in_data  = '0;
    bus.readU    = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < GRID_COLS; i++) begin
      check("rst_up", int'($signed(bus.up[i])), 0);
      check("rst_level", int'(bus.level[i]), 0);
      bus.in_lane = 2'(i);
      #1;
      check("rst_in_ready", int'(bus.in_ready), 1);
    end
    check("rst_rreadyU", int'(bus.rreadyU), 0);
    rst = 1'b1;
    idle_cycles(2, 4'b0000);

    // Three words to lane 2, then pop them one per cycle.
    drive(1'b1, 2'd2, 5, 4'b0000, 1'b0);
    drive(1'b1, 2'd2, -7, 4'b0000, 1'b0);
    drive(1'b1, 2'd2, 999, 4'b0000, 1'b0);
    bus.in_valid = 1'b0;
    check("t1_rreadyU", int'(bus.rreadyU), 4);
    check("t1_up2", int'($signed(bus.up[2])), 5);
    drive(1'b0, 2'd0, 0, 4'b0100, 1'b0);
    check("t1_up2_b", int'($signed(bus.up[2])), -7);
    drive(1'b0, 2'd0, 0, 4'b0100, 1'b0);
    check("t1_up2_c", int'($signed(bus.up[2])), 999);
    drive(1'b0, 2'd0, 0, 4'b0100, 1'b0);
    check("t1_empty", int'(bus.rreadyU[2]), 0);

    // Fill lane 0 and hold a ninth push until one pop frees a slot.
    for (int k = 0; k < DEPTH; k++) drive(1'b1, 2'd0, k * 10 - 35, 4'b0000, 1'b0);
    bus.in_valid = 1'b0;
    #1;
    check("t2_ready_l0", int'(bus.in_ready), 0);
    bus.in_lane = 2'd1;
    #1;
    check("t2_ready_l1", int'(bus.in_ready), 1);
    check("t2_full", int'(bus.level[0]), DEPTH);
    drive(1'b1, 2'd0, 77, 4'b0000, 1'b0);
    drive(1'b1, 2'd0, 77, 4'b0000, 1'b0);
    check("t2_held", int'(bus.level[0]), DEPTH);
    drive(1'b1, 2'd0, 77, 4'b0001, 1'b0);
    check("t2_popped", int'(bus.level[0]), DEPTH - 1);
    drive(1'b1, 2'd0, 77, 4'b0000, 1'b0);
    check("t2_refill", int'(bus.level[0]), DEPTH);
    idle_cycles(DEPTH, 4'b0001);
    check("t2_drained", int'(bus.level[0]), 0);

    // Same-cycle push and pop on lane 1 at level 3.
    drive(1'b1, 2'd1, 101, 4'b0000, 1'b0);
    drive(1'b1, 2'd1, 102, 4'b0000, 1'b0);
    drive(1'b1, 2'd1, 103, 4'b0000, 1'b0);
    drive(1'b1, 2'd1, 104, 4'b0010, 1'b0);
    check("t3_level", int'(bus.level[1]), 3);
    check("t3_head", int'($signed(bus.up[1])), 102);
    idle_cycles(4, 4'b1111);

    // Pops on all-empty lanes are ignored.
    idle_cycles(2, 4'b1111);
    for (int i = 0; i < GRID_COLS; i++) check("t4_level", int'(bus.level[i]), 0);
    check("t4_rreadyU", int'(bus.rreadyU), 0);

    // Conversion of out-of-range host values.
`ifdef TIS_INFEED_CLAMP_EN
    exp_a = 999;
    exp_b = -999;
`else
    exp_a = -548;
    exp_b = 48;
`endif
    drive(1'b1, 2'd0, 1500, 4'b0000, 1'b0);
    drive(1'b1, 2'd0, -2000, 4'b0000, 1'b0);
    check("t5_conv_a", int'($signed(bus.up[0])), exp_a);
    drive(1'b0, 2'd0, 0, 4'b0001, 1'b0);
    check("t5_conv_b", int'($signed(bus.up[0])), exp_b);
    drive(1'b0, 2'd0, 0, 4'b0001, 1'b0);

    // Flush with a competing push and pop, then a mid-stream reset.
    for (int k = 0; k < 3; k++) drive(1'b1, 2'd3, 40 + k, 4'b0000, 1'b0);
    drive(1'b1, 2'd3, 55, 4'b1000, 1'b1);
    check("t6_flush_level", int'(bus.level[3]), 0);
    check("t6_flush_rready", int'(bus.rreadyU), 0);
    for (int k = 0; k < 3; k++) drive(1'b1, 2'd3, 60 + k, 4'b0000, 1'b0);
    drive(1'b1, 2'd0, 9, 4'b0000, 1'b0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("t6_rst_level", int'(bus.level[3]), 0);
    check("t6_rst_rready", int'(bus.rreadyU), 0);
    check("t6_rst_up", int'($signed(bus.up[3])), 0);
    #1;
    rst = 1'b1;
    idle_cycles(1, 4'b0000);

    // Random traffic, including occasional flushes.
    for (int k = 0; k < 3000; k++) begin
      int d;
      if ($urandom_range(0, 3) == 0) d = int'($signed(16'($urandom())));
      else                           d = int'($urandom_range(0, 1998)) - 999;
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), d,
            4'($urandom_range(0, 15)), $urandom_range(0, 99) == 0);
    end
    idle_cycles(DEPTH + 2, 4'b1111);
    for (int i = 0; i < GRID_COLS; i++) check("final_level", int'(bus.level[i]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
